// File: rtl/seq_mul_acc.sv
// Sequential shift-add multiplier with optional accumulate into the held result.
// One operation takes WIDTH RUN cycles; o/ovf update together with a one-cycle done pulse.
module seq_mul_acc #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 acc_en,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   o,
    output logic                 ovf,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   part_q, part_d;
    logic            acc_q, acc_d;
    logic [PW-1:0]   o_q, o_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic [PW-1:0]   part_next;
    logic [PW:0]     acc_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            part_q   <= '0;
            acc_q    <= 1'b0;
            o_q      <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            part_q   <= part_d;
            acc_q    <= acc_d;
            o_q      <= o_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        part_d   = part_q;
        acc_d    = acc_q;
        o_d      = o_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        part_next = part_q + (mplier_q[0] ? mcand_q : '0);
        // o is untouched during RUN, so o_q here is still the value seen at the start edge
        acc_sum   = {1'b0, o_q} + {1'b0, part_next};

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = acc_en;
                    part_d   = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                part_d   = part_next;
                mplier_d = mplier_q >> 1;
                mcand_d  = mcand_q << 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (acc_q) begin
                        o_d   = acc_sum[PW-1:0];
                        ovf_d = acc_sum[PW];
                    end else begin
                        o_d   = part_next;
                        ovf_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign o    = o_q;
    assign ovf  = ovf_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_mul_acc.sv
// Bench for seq_mul_acc: transaction-level model compared every cycle, plus
// directed scenarios with hand-computed results for WIDTH=4 and WIDTH=8.
module tb_seq_mul_acc;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start, acc_en;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] o;
    logic           ovf, busy, done;

    logic           start8, acc8;
    logic [7:0]     a8, b8;
    logic [15:0]    o8;
    logic           ovf8, busy8, done8;

    seq_mul_acc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_en(acc_en),
        .a(a), .b(b), .o(o), .ovf(ovf), .busy(busy), .done(done)
    );

    seq_mul_acc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .acc_en(acc8),
        .a(a8), .b(b8), .o(o8), .ovf(ovf8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Transaction model: countdown of W cycles, result computed arithmetically at acceptance
    int         m_rem = 0;
    int         m_full;
    logic [7:0] m_o = '0, m_pend_o = '0;
    logic       m_ovf = 1'b0, m_pend_ovf = 1'b0, m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  = 0;
            m_o    = '0;
            m_ovf  = 1'b0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_o    = m_pend_o;
                    m_ovf  = m_pend_ovf;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_full     = int'(a) * int'(b) + (acc_en ? int'(m_o) : 0);
                m_pend_o   = m_full[7:0];
                m_pend_ovf = m_full[8];
                m_rem      = W;
            end
        end
    end

    logic chk_en = 1'b0;
    logic prev_done = 1'b0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (chk_en) begin
            chk("o", o, m_o);
            chk("ovf", ovf, m_ovf);
            chk("busy", busy, (m_rem > 0));
            chk("done", done, m_done);
            chk("done_repeat", prev_done & done, 0);
        end
        prev_done = done;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(output int t);
        bit ok;
        ok = 1'b0;
        t  = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tacc);
        int t0, td;
        step();
        start = 1'b1; a = ta; b = tb_v; acc_en = tacc;
        t0 = cyc + 1;
        step();
        start = 1'b0;
        wait_done(td);
        chk("latency", td - t0, W);
    endtask

    initial begin
        int t0, td, prev_t, dc0, ea, eb;
        rst = 1'b1; start = 1'b0; acc_en = 1'b0; a = '0; b = '0;
        start8 = 1'b0; acc8 = 1'b0; a8 = '0; b8 = '0;
        step();
        step();
        chk("reset_o", o, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_op(4'd15, 4'd15, 1'b0);
        chk("mul_15x15_o", o, 225);
        chk("mul_15x15_ovf", ovf, 0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        run_op(4'd15, 4'd15, 1'b1);
        chk("acc1_o", o, 225);
        chk("acc1_ovf", ovf, 0);
        run_op(4'd15, 4'd15, 1'b1);
        chk("acc2_o", o, 194);
        chk("acc2_ovf", ovf, 1);

        dc0 = done_cnt;
        step();
        start = 1'b1; a = 4'd3; b = 4'd5; acc_en = 1'b0;
        t0 = cyc + 1;
        step();
        start = 1'b0;
        step();
        start = 1'b1; a = 4'd7; b = 4'd7;
        step();
        start = 1'b0;
        wait_done(td);
        chk("ignore_latency", td - t0, W);
        chk("ignore_o", o, 15);
        repeat (8) step();
        chk("ignore_single_done", done_cnt - dc0, 1);

        step();
        start = 1'b1; a = 4'd9; b = 4'd9; acc_en = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        dc0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("abort_o", o, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        step();
        step();
        rst = 1'b0;
        start = 1'b1; a = 4'd2; b = 4'd3; acc_en = 1'b0;
        t0 = cyc + 1;
        step();
        start = 1'b0;
        wait_done(td);
        chk("post_rst_latency", td - t0, W);
        chk("post_rst_o", o, 6);
        chk("abort_no_done", done_cnt - dc0, 1);

        step();
        start = 1'b1; a = 4'd0; b = 4'd0; acc_en = 1'b0;
        step();
        start = 1'b0;
        prev_t = 0;
        for (int i = 0; i < 256; i++) begin
            ea = i / 16;
            eb = i % 16;
            wait_done(td);
            chk("sweep_o", o, ea * eb);
            if (i > 0) chk("sweep_period", td - prev_t, W + 1);
            prev_t = td;
            if (i < 255) begin
                start = 1'b1;
                a = W'((i + 1) / 16);
                b = W'((i + 1) % 16);
                step();
                start = 1'b0;
            end
        end

        step();
        start8 = 1'b1; a8 = 8'd255; b8 = 8'd255; acc8 = 1'b0;
        t0 = cyc + 1;
        step();
        start8 = 1'b0;
        chk("w8_busy", busy8, 1);
        td = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done8) begin
                td = cyc;
                break;
            end
        end
        chk("w8_latency", td - t0, 8);
        chk("w8_o", o8, 65025);
        chk("w8_ovf", ovf8, 0);

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
